// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares one synchronous FIFO write port among NREQ
// requesters. Arbitration is round-robin and each burst is bounded.
// The IDLE state picks the next owner. The BURST state forwards the owner's
// words in the same cycle they are presented, and never while the FIFO is full.
// Optional build macro FWA_STATS_EN adds saturating words_written and
// stall_cycles counters.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    input  logic              fifo_full,
    output logic              fifo_wn,
    output logic [DW-1:0]     fifo_din
`ifdef FWA_STATS_EN
    ,
    output logic [15:0]       words_written,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = OW + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;

    logic [DW-1:0]   word [NREQ];
    logic [OW-1:0]   sel_idx;
    logic            sel_found;
    logic [SW-1:0]   cand_sum;
    logic [OW-1:0]   cand;
    logic            owner_req;
    logic            in_burst;

    // Unpack the flat request bus and build the one-hot ack from the owner index.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign word[gi] = req_data[gi*DW +: DW];
        assign ack[gi]  = fifo_wn && (owner_q == OW'(gi));
    end

    // Round-robin search: the first asserted request after last_owner, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, last_owner_q} + SW'(k);
            cand     = OW'((cand_sum >= SW'(NREQ)) ? cand_sum - SW'(NREQ) : cand_sum);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Combinational write path: a word is taken in the cycle it is offered,
    // unless the FIFO is full or reset is high.
    always_comb begin
        in_burst  = (state_q == BURST);
        owner_req = req[owner_q];
        fifo_wn   = in_burst && owner_req && !fifo_full && !reset;
        fifo_din  = fifo_wn ? word[owner_q] : '0;
    end

    assign grant = grant_q;

    // Next-state logic: arbitrate in IDLE; in BURST count words, release or stall.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        grant_d      = grant_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = BURST;
                    owner_d     = sel_idx;
                    grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    // Owner released early; nothing is written this cycle.
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    grant_d      = '0;
                end else if (fifo_wn) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (burst_cnt_q == 8'(MAX_BURST - 1)) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                        grant_d      = '0;
                    end
                end
                // Owner requesting while the FIFO is full: hold everything.
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; last_owner starts at NREQ-1 so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NREQ - 1);
            burst_cnt_q  <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            grant_q      <= grant_d;
        end
    end

`ifdef FWA_STATS_EN
    logic [15:0] words_q, words_d;
    logic [15:0] stall_q, stall_d;

    // Saturating counters for writes and owner stalls on a full FIFO.
    always_comb begin
        words_d = words_q;
        stall_d = stall_q;
        if (fifo_wn && (words_q != 16'hFFFF)) begin
            words_d = words_q + 16'd1;
        end
        if (in_burst && owner_req && fifo_full && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            words_q <= words_d;
            stall_q <= stall_d;
        end
    end

    assign words_written = words_q;
    assign stall_cycles  = stall_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NREQ=4, DW=32, MAX_BURST=4).
// With FWA_STATS_EN defined, a second instance (NREQ=2, MAX_BURST=255)
// exercises the statistics counters.
module tb_fifo_write_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic         fifo_full;
    logic         fifo_wn;
    logic [31:0]  fifo_din;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

`ifdef FWA_STATS_EN
    logic [15:0] words_written, stall_cycles;
    logic        reset_s;
    logic [1:0]  req_s, ack_s, grant_s;
    logic [63:0] req_data_s;
    logic        fifo_full_s, fifo_wn_s;
    logic [31:0] fifo_din_s;
    logic [15:0] words_s, stall_s;
`endif

    fifo_write_arbiter #(.NREQ(4), .DW(32), .MAX_BURST(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant     (grant),
        .fifo_full (fifo_full),
        .fifo_wn   (fifo_wn),
        .fifo_din  (fifo_din)
`ifdef FWA_STATS_EN
        ,
        .words_written (words_written),
        .stall_cycles  (stall_cycles)
`endif
    );

`ifdef FWA_STATS_EN
    fifo_write_arbiter #(.NREQ(2), .DW(32), .MAX_BURST(255)) dut_s (
        .clock         (clock),
        .reset         (reset_s),
        .req           (req_s),
        .req_data      (req_data_s),
        .ack           (ack_s),
        .grant         (grant_s),
        .fifo_full     (fifo_full_s),
        .fifo_wn       (fifo_wn_s),
        .fifo_din      (fifo_din_s),
        .words_written (words_s),
        .stall_cycles  (stall_s)
    );
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Reset for one edge; returns in the first IDLE cycle after reset.
    task automatic do_reset;
        req   = 4'b0000;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // Checks one write cycle for requester r.
    task automatic chk_write(input string tag, input int r);
        logic [3:0]  oh;
        logic [31:0] w;
        oh = 4'b0001 << r;
        w  = 32'hA0 + 32'(r);
        $display("%s: owner=%0d grant=%b ack=%b wn=%b din=%0h", tag, r, grant, ack, fifo_wn, fifo_din);
        chk({tag, "_wn"},    64'(fifo_wn),  64'd1);
        chk({tag, "_ack"},   64'(ack),      64'(oh));
        chk({tag, "_grant"}, 64'(grant),    64'(oh));
        chk({tag, "_din"},   64'(fifo_din), 64'(w));
    endtask

    // Checks an IDLE or no-write cycle.
    task automatic chk_idle(input string tag, input logic [3:0] exp_grant);
        $display("%s: grant=%b ack=%b wn=%b din=%0h", tag, grant, ack, fifo_wn, fifo_din);
        chk({tag, "_wn"},    64'(fifo_wn),  64'd0);
        chk({tag, "_ack"},   64'(ack),      64'd0);
        chk({tag, "_din"},   64'(fifo_din), 64'd0);
        chk({tag, "_grant"}, 64'(grant),    64'(exp_grant));
    endtask

    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        fifo_full = 1'b0;
        req_data  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
`ifdef FWA_STATS_EN
        reset_s     = 1'b1;
        req_s       = 2'b00;
        fifo_full_s = 1'b0;
        req_data_s  = {32'hB1, 32'hB0};
`endif

        // Reset state
        next_cycle();
        next_cycle();
        chk_idle("reset", 4'b0000);

        // Single requester: 4-word bursts, one IDLE cycle, then re-grant
        reset = 1'b0;
        req   = 4'b0001;
        settle();
        chk_idle("t1_c1", 4'b0000);
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            chk_write($sformatf("t1_c%0d", c), 0);
        end
        next_cycle();
        chk_idle("t1_c6", 4'b0000);
        next_cycle();
        chk_write("t1_c7", 0);

        // All requesting: grant order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        settle();
        chk_idle("t2_arb", 4'b0000);
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < 4; j++) begin
                next_cycle();
                chk_write($sformatf("t2_b%0d_w%0d", b, j), b % 4);
            end
            next_cycle();
            chk_idle($sformatf("t2_b%0d_idle", b), 4'b0000);
        end

        // Owner 2 stalls on full for 3 cycles after 2 words
        do_reset();
        req = 4'b0100;
        settle();
        chk_idle("t3_arb", 4'b0000);
        next_cycle();
        chk_write("t3_w0", 2);
        next_cycle();
        chk_write("t3_w1", 2);
        next_cycle();
        fifo_full = 1'b1;
        settle();
        chk_idle("t3_stall0", 4'b0100);
        next_cycle();
        chk_idle("t3_stall1", 4'b0100);
        next_cycle();
        chk_idle("t3_stall2", 4'b0100);
        next_cycle();
        fifo_full = 1'b0;
        settle();
        chk_write("t3_w2", 2);
        next_cycle();
        chk_write("t3_w3", 2);
        next_cycle();
        chk_idle("t3_end", 4'b0000);

        // Owner 1 releases after one word while requester 3 waits
        do_reset();
        req = 4'b1010;
        settle();
        chk_idle("t4_arb", 4'b0000);
        next_cycle();
        chk_write("t4_w0", 1);
        next_cycle();
        req = 4'b1000;
        settle();
        chk_idle("t4_drop", 4'b0010);
        next_cycle();
        chk_idle("t4_idle", 4'b0000);
        next_cycle();
        chk_write("t4_own3", 3);

        // Reset during a burst with one word written
        next_cycle();
        reset = 1'b1;
        settle();
        chk_idle("t5_rst_in_burst", 4'b1000);
        next_cycle();
        reset = 1'b0;
        req   = 4'b1001;
        settle();
        chk_idle("t5_after_rst", 4'b0000);
        next_cycle();
        chk_write("t5_regrant", 0);
        req = 4'b0000;
        next_cycle();

`ifdef FWA_STATS_EN
        begin
            int n;
            int cyc;
            reset_s = 1'b1;
            next_cycle();
            reset_s = 1'b0;
            req_s   = 2'b01;
            n   = 0;
            cyc = 0;
            while (n < 70000 && cyc < 80000) begin
                next_cycle();
                cyc++;
                if (fifo_wn_s) n++;
            end
            next_cycle();
            $display("stats: writes=%0d cycles=%0d words_written=%0h", n, cyc, words_s);
            chk("stats_write_count", 64'(n), 64'd70000);
            chk("stats_words_sat", 64'(words_s), 64'hFFFF);

            req_s   = 2'b00;
            reset_s = 1'b1;
            next_cycle();
            reset_s = 1'b0;
            req_s   = 2'b01;
            next_cycle();
            fifo_full_s = 1'b1;
            for (int k = 0; k < 4; k++) next_cycle();
            next_cycle();
            fifo_full_s = 1'b0;
            settle();
            $display("stats: stall_cycles=%0d words_written=%0d", stall_s, words_s);
            chk("stats_stall", 64'(stall_s), 64'd5);
            chk("stats_words_after_rst", 64'(words_s), 64'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one sync FIFO write port among NREQ requesters using round-robin arbitration with bounded bursts.
- Sits between the producer blocks and the FIFO's wn/DATAIN/full pins.
- Forwards at most one word per cycle and never writes while the FIFO reports full.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data word width; matches the FIFO DATAIN width.
- MAX_BURST, 4, maximum consecutive words granted to one owner before re-arbitration (1..255).

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester "word available" level; must hold until acked.
- req_data  input  NREQ*DW  packed request words; requester i uses bits [i*DW +: DW].
- ack  output  NREQ  one-hot; a pulse means requester i's word was written this cycle.
- grant  output  NREQ  one-hot current burst owner; all zero in IDLE.
- fifo_full  input  1  FIFO full flag.
- fifo_wn  output  1  FIFO write enable.
- fifo_din  output  DW  FIFO write data.

Behaviour:
- Clocking and reset:
  - One clock, clock.
  - reset is synchronous and active-high.
  - Reset sets state=IDLE, grant=0, owner index=0, last_owner=NREQ-1 (so requester 0 wins first), burst count=0.
  - Outputs while reset is high: fifo_wn=0, ack=0, fifo_din=0.
- States: IDLE and BURST. state, owner, last_owner and burst_cnt are registered.
- IDLE:
  - If req is non-zero, select the first asserted requester, searching upward with wrap from last_owner+1.
  - Next cycle: state=BURST, owner=selected, grant=onehot(owner), burst_cnt=0.
  - No write ever occurs in IDLE, so arbitration costs 1 cycle per burst.
- BURST, combinational write path:
  - fifo_wn = req[owner] & ~fifo_full.
  - fifo_din = owner's word (forced to 0 when fifo_wn=0).
  - ack[owner] = fifo_wn; all other ack bits are 0.
  - Latency: a word is accepted in the same cycle it is presented.
- BURST, on each write:
  - burst_cnt increments.
  - If burst_cnt reaches MAX_BURST-1 on this write, go to IDLE, set last_owner=owner and clear grant.
- BURST, release and stall:
  - If req[owner]=0, go to IDLE and set last_owner=owner. No write occurs that cycle.
  - If req[owner]=1 and fifo_full=1, stay in BURST with no write and no ack. burst_cnt holds, so the owner keeps its grant through a stall.
- Fairness: after a burst ends, the old owner has lowest priority in the next arbitration. A requester never waits more than (NREQ-1) bursts.
- Requests from non-owners are ignored during BURST. They may change freely.
- Reset during BURST: the next cycle is IDLE with no write and all registers back to their reset values.
- fifo_full and the write decision happen in the same cycle, so the FIFO cannot be overflowed by the arbiter.

Optional Feature:
- Macro: FWA_STATS_EN.
- Defined:
  - Adds output words_written, 16 bits: a saturating count of fifo_wn cycles. It holds at 16'hFFFF.
  - Adds output stall_cycles, 16 bits: a saturating count of BURST cycles where req[owner]=1 and fifo_full=1.
  - Both counters clear on reset.
- Undefined: neither port nor the counter logic exists. Behaviour is otherwise identical.

Test Plan:
- Reset, then req=4'b0001 held, word0=32'hA0 -> ack[0] pulses on cycles 2..5 (4 words), IDLE on cycle 6, re-grant to requester 0 on cycle 7; fifo_din=32'hA0 on each write.
- req=4'b1111 held, fifo_full=0 -> grant order 0,1,2,3,0; each burst is 4 acks followed by 1 IDLE cycle; no write while grant=0.
- Owner 2 mid-burst after 2 words, fifo_full=1 for 3 cycles -> fifo_wn=0, ack=0 and grant stays 4'b0100; after full drops, exactly 2 more words are written, then IDLE.
- Owner 1 drops req after 1 word while req[3]=1 -> IDLE next cycle, then grant=4'b1000; requester 1 gets no further acks in that burst.
- reset asserted in BURST with 1 word written -> next cycle: state IDLE, grant=0, fifo_wn=0; the next arbitration starts the search from requester 0.
- With FWA_STATS_EN defined: 70000 back-to-back writes -> words_written=16'hFFFF; 5 full-stall cycles -> stall_cycles=5.
